// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//
// ID/EX pipeline register with a valid/ready handshake on both sides and a
// 2-entry skid buffer. Backpressure from execute (out_ready_i) does not reach
// decode combinationally: in_ready_o depends only on the state register.
// Slots that are empty or were flushed present CTRL_KILL on out_ctrl_o, so
// bubbles never cause side effects in execute.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both high on that side. The producer must hold valid and its payload
// until the transfer happens. in_ready_o is registered. out_valid_o and the
// head entry stay constant while out_ready_i is low.
//
// Ports
//   clk_i        in   clock, all state on posedge
//   rst_n_i      in   asynchronous active-low reset
//   flush_i      in   synchronous kill of all held entries (wins over acc/pop)
//   in_valid_i   in   decode offers an instruction
//   in_ready_o   out  stage can accept (low only when both slots are full)
//   in_data_i    in   decode payload   [DATA_W]
//   in_ctrl_i    in   decode control   [CTRL_W]
//   out_valid_o  out  head entry valid
//   out_ready_i  in   execute consumes the head this cycle
//   out_data_o   out  head payload     [DATA_W]
//   out_ctrl_o   out  head control, CTRL_KILL when out_valid_o=0
//   occ_o        out  entries held (0..2); this is also the FSM state
//   stall_cnt_o  out  saturating count of out_valid_o & !out_ready_i cycles
//   kill_cnt_o   out  saturating count of entries discarded by flush
//
// Build option: define ID_EX_PERF_EN to build the two performance counters.
// Without it, stall_cnt_o and kill_cnt_o are tied to 0.
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
    parameter int                 DATA_W    = 160,
    parameter int                 CTRL_W    = 12,
    parameter logic [CTRL_W-1:0]  CTRL_KILL = '0,
    parameter int                 PERF_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occ_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] kill_cnt_o
);

    // State encoding equals the occupancy, so occ_o is the state register itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] m_data_q, s_data_q;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;

    logic acc, pop;
    logic load_m_in, load_m_s, load_s_in;

    // Slot valids are implied by the state: M valid unless EMPTY, S valid only when FULL.
    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign occ_o       = state_q;
    assign out_data_o  = m_data_q;
    assign out_ctrl_o  = out_valid_o ? m_ctrl_q : CTRL_KILL;

    assign acc = in_valid_i & in_ready_o;
    assign pop = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s_in = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d   = ST_ONE;
                    load_m_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    load_m_in = 1'b1;
                end else if (acc) begin
                    state_d   = ST_FULL;
                    load_s_in = 1'b1;
                end else if (pop) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready_o is low here, so only a pop can change anything.
                if (pop) begin
                    state_d  = ST_ONE;
                    load_m_s = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A handshake in a flush cycle is accepted upstream but discarded here.
        if (flush_i) begin
            state_d   = ST_EMPTY;
            load_m_in = 1'b0;
            load_m_s  = 1'b0;
            load_s_in = 1'b0;
        end
    end

    // Payload is never cleared by flush; only the control slots are killed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_data_q <= '0;
            m_ctrl_q <= CTRL_KILL;
            s_data_q <= '0;
            s_ctrl_q <= CTRL_KILL;
        end else if (flush_i) begin
            m_ctrl_q <= CTRL_KILL;
            s_ctrl_q <= CTRL_KILL;
        end else begin
            if (load_m_in) begin
                m_data_q <= in_data_i;
                m_ctrl_q <= in_ctrl_i;
            end else if (load_m_s) begin
                m_data_q <= s_data_q;
                m_ctrl_q <= s_ctrl_q;
            end
            if (load_s_in) begin
                s_data_q <= in_data_i;
                s_ctrl_q <= in_ctrl_i;
            end else if (load_m_s) begin
                s_ctrl_q <= CTRL_KILL;
            end
        end
    end

`ifdef ID_EX_PERF_EN
    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] kill_q, kill_d;
    logic [PERF_W:0]   kill_sum;

    // Extra carry bit detects overflow of the kill accumulation.
    assign kill_sum = {1'b0, kill_q} + (PERF_W+1)'(occ_o);

    always_comb begin
        stall_d = stall_q;
        kill_d  = kill_q;
        if (out_valid_o && !out_ready_i && (stall_q != {PERF_W{1'b1}})) begin
            stall_d = stall_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
        if (flush_i) begin
            kill_d = kill_sum[PERF_W] ? {PERF_W{1'b1}} : kill_sum[PERF_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
            kill_q  <= '0;
        end else begin
            stall_q <= stall_d;
            kill_q  <= kill_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign kill_cnt_o  = kill_q;
`else
    assign stall_cnt_o = '0;
    assign kill_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg. The model treats the stage as a FIFO of depth 2
// with perfect order, plus two saturating counters.
module tb_id_ex_skid_reg;

  localparam int            DW   = 32;
  localparam int            CW   = 8;
  localparam int            PW   = 4;
  localparam logic [CW-1:0] KILL = 8'hA5;
  localparam int            SAT  = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occ;
  logic [PW-1:0] stall_cnt;
  logic [PW-1:0] kill_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  id_ex_skid_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_KILL(KILL), .PERF_W(PW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ctrl_o(out_ctrl),
    .occ_o(occ), .stall_cnt_o(stall_cnt), .kill_cnt_o(kill_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [DW+CW-1:0] exp_q[$];
  int m_stall = 0;
  int m_kill = 0;

  function automatic int perf_exp(input int v);
`ifdef ID_EX_PERF_EN
    return (v > SAT) ? SAT : v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_stall = 0;
      m_kill = 0;
    end else begin
      bit acc, pop;
      acc = in_valid && (exp_q.size() < 2);
      pop = (exp_q.size() > 0) && out_ready;
      if ((exp_q.size() > 0) && !out_ready) m_stall++;
      if (flush) begin
        m_kill += exp_q.size();
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({in_data, in_ctrl});
      end
    end
  end

  // compare process: every falling edge
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    chk("occ", 64'(occ), 64'(exp_q.size()));
    if (exp_q.size() != 0) chk("head", 64'({out_data, out_ctrl}), 64'(exp_q[0]));
    else chk("idle_ctrl", 64'(out_ctrl), 64'(KILL));
    chk("stall_cnt", 64'(stall_cnt), 64'(perf_exp(m_stall)));
    chk("kill_cnt", 64'(kill_cnt), 64'(perf_exp(m_kill)));
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input bit r, input bit f);
    in_valid = v;
    in_data = d;
    in_ctrl = c;
    out_ready = r;
    flush = f;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit r);
    step(1'b0, '0, '0, r, 1'b0);
  endtask

  logic [DW-1:0] td[4];
  logic [CW-1:0] tc[4];
  logic [DW-1:0] held_d;
  logic [CW-1:0] held_c;

  initial begin
    td[0] = 32'hAAAA_0001; tc[0] = 8'h11;
    td[1] = 32'hBBBB_0002; tc[1] = 8'h22;
    td[2] = 32'hCCCC_0003; tc[2] = 8'h33;
    td[3] = 32'hDDDD_0004; tc[3] = 8'h44;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    // 1. reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'(KILL));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occ", 64'(occ), 64'd0);
    rst_n = 1'b1;
    idle(1'b0);

    // 2. stream A..D with out_ready=1
    for (int i = 0; i < 4; i++) begin
      step(1'b1, td[i], tc[i], 1'b1, 1'b0);
      chk("stream_head", 64'({out_data, out_ctrl}), 64'({td[i], tc[i]}));
      chk("stream_occ", 64'(occ), 64'd1);
    end
    idle(1'b1);
    chk("stream_drained", 64'(out_valid), 64'd0);

    // 3. backpressure: A in M, B in S, C held upstream
    step(1'b1, td[0], tc[0], 1'b0, 1'b0);
    step(1'b1, td[1], tc[1], 1'b0, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occ", 64'(occ), 64'd2);
    step(1'b1, td[2], tc[2], 1'b0, 1'b0);
    chk("bp_head_a", 64'(out_data), 64'(td[0]));
    step(1'b1, td[2], tc[2], 1'b1, 1'b0);
    chk("bp_head_b", 64'(out_data), 64'(td[1]));
    step(1'b1, td[2], tc[2], 1'b1, 1'b0);
    chk("bp_head_c", 64'({out_data, out_ctrl}), 64'({td[2], tc[2]}));
    idle(1'b1);
    chk("bp_drained", 64'(occ), 64'd0);

    // 4. flush in FULL with out_ready=1 and in_valid=1
    step(1'b1, td[0], tc[0], 1'b0, 1'b0);
    step(1'b1, td[1], tc[1], 1'b0, 1'b0);
    step(1'b1, td[3], tc[3], 1'b1, 1'b1);
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'(KILL));
    chk("flush_in_ready", 64'(in_ready), 64'd1);
`ifdef ID_EX_PERF_EN
    chk("flush_kill_cnt", 64'(kill_cnt), 64'd2);
`else
    chk("flush_kill_cnt", 64'(kill_cnt), 64'd0);
`endif
    idle(1'b1);

    // clear the counters before the hold check
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    idle(1'b0);

    // 5. hold check: 5 stall cycles with M valid
    step(1'b1, td[3], tc[3], 1'b0, 1'b0);
    held_d = out_data;
    held_c = out_ctrl;
    chk("hold_first", 64'({held_d, held_c}), 64'({td[3], tc[3]}));
    repeat (5) idle(1'b0);
    chk("hold_data", 64'(out_data), 64'(held_d));
    chk("hold_ctrl", 64'(out_ctrl), 64'(held_c));
`ifdef ID_EX_PERF_EN
    chk("hold_stall_cnt", 64'(stall_cnt), 64'd5);
`else
    chk("hold_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    idle(1'b1);

    // 6. asynchronous reset mid-drain in FULL
    step(1'b1, td[0], tc[0], 1'b0, 1'b0);
    step(1'b1, td[1], tc[1], 1'b0, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occ), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_ctrl", 64'(out_ctrl), 64'(KILL));
    chk("arst_out_data", 64'(out_data), 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    step(1'b1, td[2], tc[2], 1'b1, 1'b0);
    chk("arst_first_accept", 64'({out_valid, out_data, out_ctrl}), 64'({1'b1, td[2], tc[2]}));
    idle(1'b1);

    // counter saturation
    step(1'b1, td[0], tc[0], 1'b0, 1'b0);
    repeat (20) idle(1'b0);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'(perf_exp(100)));
    idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, td[0], tc[0], 1'b0, 1'b0);
      step(1'b1, td[1], tc[1], 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b1);
    end
    chk("sat_kill_cnt", 64'(kill_cnt), 64'(perf_exp(16)));
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
